// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one grant at a time, held until done/request drop,
// with per-requester weights giving back-to-back bonus grants and a hold timeout.
module wrr_arbiter #(
  parameter int N   = 4,
  parameter int WW  = 2,
  parameter int TMO = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          done,
  input  logic [N*WW-1:0]       weight,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(TMO);
  localparam logic [HW-1:0] HOLD_LAST = HW'(TMO - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [WW-1:0] cred;
  logic [HW-1:0] hold;

  logic          win_found;
  logic [IW-1:0] win_id;
  logic [IW-1:0] scan_id;
  logic [WW-1:0] win_weight;
  logic [WW-1:0] next_cred;
  logic [IW-1:0] next_ptr;
  logic          release_now;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (int'(v) == N - 1) ? '0 : v + 1'b1;
  endfunction

  // Scan from the farthest offset down so the offset closest to ptr wins last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_id = IW'((int'(ptr) + i) % N);
      if (req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_comb begin
    win_weight = weight[int'(win_id)*WW +: WW];
    if ((win_id == ptr) && (cred != '0)) begin
      next_cred = cred - 1'b1;
    end else begin
      next_cred = win_weight;
    end
    next_ptr = (next_cred == '0) ? wrap_inc(win_id) : win_id;
  end

  assign release_now = done[grant_id] | ~req[grant_id];

  // Release is checked before the hold limit so a coincident done never times out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      ptr         <= '0;
      cred        <= '0;
      hold        <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= BUSY;
            grant       <= N'(1) << win_id;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
            hold        <= '0;
            cred        <= next_cred;
            ptr         <= next_ptr;
          end
        end
        BUSY: begin
          if (release_now) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end else if (hold == HOLD_LAST) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b1;
            ptr         <= wrap_inc(grant_id);
            cred        <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WW, default 2, per-requester weight width in bits.
REQ-003 SHALL have parameter TMO, default 16, maximum grant hold in cycles (>=2).
REQ-004 SHALL have port clk  input  1  clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  N  request bit per requester, level-held until serviced.
REQ-007 SHALL have port done  input  N  one-cycle release pulse from the requester that owns the grant.
REQ-008 SHALL have port weight  input  N*WW  weight of requester k in bits [k*WW +: WW]; value w gives w+1 back-to-back grants.
REQ-009 SHALL have port grant  output  N  one-hot grant, all-zero when idle.
REQ-010 SHALL have port grant_valid  output  1  high while any grant is held.
REQ-011 SHALL have port grant_id  output  clog2(N)  index of the granted requester; 0 when idle.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-014 SHALL keep internal state ptr (clog2(N) bits, the round-robin start index) and cred (WW bits, remaining bonus grants for ptr).
REQ-015 In IDLE with req != 0: winner w = first index with req set, scanning ptr, ptr+1, ... modulo N; the FSM moves to BUSY and grant[w], grant_valid and grant_id=w are registered, visible the next cycle (1-cycle latency).
REQ-016 In IDLE with req == 0: outputs stay idle and ptr/cred are unchanged.
REQ-017 Credit update on a grant decision: if w==ptr and cred>0 then cred<=cred-1, else cred<=weight[w], with weight sampled in the decision cycle only.
REQ-018 Pointer update on a grant decision: if the new cred value is 0 then ptr<=(w+1) mod N, else ptr<=w.
REQ-019 In BUSY, release occurs when done[grant_id]==1 or req[grant_id]==0; grant, grant_valid and grant_id clear the next cycle, and the FSM returns to IDLE.
REQ-020 After a release, at least one IDLE cycle SHALL separate consecutive grants; back-to-back grants without an idle cycle are forbidden.
REQ-021 done bits of non-granted requesters, and any done in IDLE, SHALL be ignored.
REQ-022 A hold counter SHALL clear to 0 on grant and increment each BUSY cycle; if it equals TMO-1 with no release in that cycle, the grant is revoked next cycle, timeout pulses for exactly that one cycle, ptr<=(grant_id+1) mod N and cred<=0.
REQ-023 If a release and the timeout condition occur in the same cycle, the release wins: no timeout pulse, and normal ptr/cred state is kept.
REQ-024 Requests changing during BUSY SHALL not affect the current grant except via REQ-019.
REQ-025 grant SHALL never have more than one bit set, and grant_valid SHALL equal |grant in every cycle.

Reset
REQ-026 While rst is high at a clock edge: state<=IDLE, grant<=0, grant_valid<=0, grant_id<=0, timeout<=0, ptr<=0, cred<=0, hold counter<=0.
REQ-027 rst asserted during BUSY SHALL drop the grant on the next edge regardless of done; no timeout pulse is generated.

Verification
REQ-028 All weights 0, req=4'b1111 with each owner pulsing done 1 cycle after grant: grant order 0,1,2,3,0, one idle cycle between grants.
REQ-029 weight[0]=2, others 0, req=4'b1111, done each grant: grant order 0,0,0,1,2,3,0.
REQ-030 Only req[2] set, never done, TMO=16: grant[2] held 16 cycles, then revoked; timeout high 1 cycle; ptr=3; req[2] is re-granted after one idle cycle.
REQ-031 done[grant_id] coincident with the hold counter at TMO-1: grant drops, timeout stays 0.
REQ-032 req=4'b0110, owner 1 drops req mid-grant: grant clears next cycle, then grant[2] follows after one idle cycle; done[3] pulses throughout are ignored.
REQ-033 rst pulsed while grant=4'b0100: next cycle all outputs 0; with req=4'b1111 the first grant after reset goes to requester 0.
